fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain stage for the project FIFO. It pops one word whenever the FIFO is
//  non-empty and enabled, then serialises the word onto a UART-style line.
//  Frame format: 1 start bit, rw data bits LSB first, 1 stop bit.
//  It connects directly to the FIFO's read strobe, empty flag, underflow flag and data output.
// PARAMETERS
//  rw   8   data word width; must equal the FIFO word width
//  cpb  16  clock cycles per serial bit; legal range 2..65535
// PORTS
//  c     in   1   clock; all logic on the rising edge
//  re    in   1   reset; synchronous, active-high
//  en    in   1   drain enable; sampled only in IDLE
//  es    in   1   FIFO empty status
//  uf    in   1   FIFO underflow status; sampled in LOAD
//  d     in   rw  FIFO read data (FIFO output o)
//  rs    out  1   FIFO read strobe; single-cycle pulse
//  tx    out  1   serial line; idles high
//  busy  out  1   high in every state except IDLE
//  err   out  1   sticky underflow error
// BEHAVIOUR
//  Reset
//   - re high at an edge: state=IDLE, tx=1, rs=0, busy=0, err=0.
//   - Bit counter, cycle counter and shift register are cleared to 0.
//   - Reset has priority over everything, including mid-frame: the frame is abandoned,
//     the popped word is lost, and tx=1 from the next edge.
//  FSM states: IDLE, POP, LOAD, START, DATA, STOP.
//   - IDLE:  if en=1 and es=0, go to POP; otherwise stay in IDLE.
//   - POP:   rs=1 for exactly this one cycle. FIFO read latency is 1, so d is valid in LOAD.
//   - LOAD:  if uf=1, set err=1, go to IDLE, send nothing.
//            Otherwise capture shreg<=d, clear counters, go to START.
//   - START: tx=0 for cpb cycles, then go to DATA.
//   - DATA:  tx=shreg[0] for cpb cycles per bit, then shift right; bit index 0..rw-1.
//            After bit rw-1 completes, go to STOP.
//   - STOP:  tx=1 for cpb cycles, then go to IDLE.
//  Timing
//   - tx is registered: it changes on the same edge that enters or advances a state/bit.
//   - The cycle counter counts 0..cpb-1 and wraps to 0 on each bit boundary; it never
//     exceeds cpb-1.
//   - Frame length on tx is (rw+2)*cpb cycles.
//   - Back-to-back rs spacing is (rw+2)*cpb+3 cycles (the POP, LOAD and IDLE overhead).
//  Boundary conditions
//   - rs is never asserted outside POP. POP is never entered while es=1 or en=0
//     (both are sampled in IDLE).
//   - en falling mid-frame has no effect; the current frame completes and the FSM
//     then stays in IDLE.
//   - es changing outside IDLE is ignored.
//   - err clears only on reset.
//   - uf outside LOAD is ignored.
//   - Illegal or unused state encodings recover to IDLE on the next edge, with tx=1.
// TESTING (rw=8, cpb=4, driven with the project FIFO, depth 32)
//  1. Hold re=1 for 2 edges with es=0, en=1 -> tx=1, rs=0, busy=0, err=0 throughout;
//     the first rs pulse comes 1 edge after re falls.
//  2. Write 8'hA5, en=1 -> one rs pulse. tx is 0 for 4 cycles, then bits
//     1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles (40 cycles total);
//     busy=0 afterwards.
//  3. Write 0..31 (FIFO full), en=1 -> 32 frames carrying 8'h00..8'h1F in order,
//     rs pulses exactly 43 cycles apart, es=1 at the end, err=0, no uf.
//  4. FIFO non-empty with en=0 -> no rs for 200 cycles. Then set en=1 and drop en
//     at bit 3 -> the frame completes all 40 cycles and no further rs follows.
//  5. Pulse re for 1 cycle during DATA bit 4 -> tx=1 on the next edge, busy=0.
//     The next rs comes 1 cycle after re falls if es=0, and the lost word is not resent.
//  6. Force uf=1 during LOAD -> err=1 and stays 1, tx stays 1 (no start bit),
//     FSM returns to IDLE; err is cleared only by re.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain stage serialising popped words onto a UART-style line
module fifo_uart_tx #(
  parameter int rw  = 8,
  parameter int cpb = 16
) (
  input  logic          c,
  input  logic          re,
  input  logic          en,
  input  logic          es,
  input  logic          uf,
  input  logic [rw-1:0] d,
  output logic          rs,
  output logic          tx,
  output logic          busy,
  output logic          err
);

  localparam int CW = $clog2(cpb);
  localparam int BW = (rw > 1) ? $clog2(rw) : 1;
  localparam logic [CW-1:0] CYC_MAX = CW'(cpb - 1);
  localparam logic [CW-1:0] CYC_ONE = CW'(1);
  localparam logic [BW-1:0] BIT_MAX = BW'(rw - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [BW-1:0] bit_idx, bit_nxt;
  logic [rw-1:0] shreg, shreg_nxt;
  logic          tx_nxt, err_nxt;
  logic          cyc_last, bit_last;

  assign cyc_last = (cyc == CYC_MAX);
  assign bit_last = (bit_idx == BIT_MAX);
  assign rs       = (state == POP);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    err_nxt   = err;
    case (state)
      IDLE: if (en && !es) state_nxt = POP;
      POP:  state_nxt = LOAD;
      LOAD: begin
        if (uf) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          shreg_nxt = d;
          cyc_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        cyc_nxt = cyc_last ? '0 : cyc + CYC_ONE;
        if (cyc_last) state_nxt = DATA;
      end
      DATA: begin
        cyc_nxt = cyc_last ? '0 : cyc + CYC_ONE;
        if (cyc_last) begin
          shreg_nxt = shreg >> 1;
          if (bit_last) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + BIT_ONE;
          end
        end
      end
      STOP: begin
        cyc_nxt = cyc_last ? '0 : cyc + CYC_ONE;
        if (cyc_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // tx is derived from where we are going so it moves on the same edge as the state/bit
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge c) begin
    if (re) begin
      state   <= IDLE;
      tx      <= 1'b1;
      err     <= 1'b0;
      cyc     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      err     <= err_nxt;
      cyc     <= cyc_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with a behavioural FIFO and frame scoreboard
module tb_fifo_uart_tx;

  localparam int RW    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (RW + 2) * CPB;

  logic          c  = 1'b0;
  logic          re = 1'b1;
  logic          en = 1'b0;
  logic          es = 1'b1;
  logic          uf = 1'b0;
  logic [RW-1:0] d  = '0;
  logic          rs, tx, busy, err;

  fifo_uart_tx #(.rw(RW), .cpb(CPB)) dut (
    .c(c), .re(re), .en(en), .es(es), .uf(uf), .d(d),
    .rs(rs), .tx(tx), .busy(busy), .err(err)
  );

  always #5 c = ~c;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Behavioural FIFO with read latency 1
  logic [RW-1:0] fq[$];
  logic [RW-1:0] exp_q[$];

  task automatic push(input logic [RW-1:0] w, input bit expect_it);
    fq.push_back(w);
    es = 1'b0;
    if (expect_it) exp_q.push_back(w);
  endtask

  always @(posedge c) begin
    if (rs === 1'b1 && fq.size() > 0) begin
      d  <= fq.pop_front();
      es <= (fq.size() == 0);
    end
  end

  int cyc_n = 0;
  always @(posedge c) cyc_n++;

  int rs_cnt = 0;
  int rs_t[$];
  always @(negedge c) begin
    if (rs === 1'b1) begin
      rs_cnt++;
      rs_t.push_back(cyc_n);
    end
  end

  // Line receiver: checks every cycle of each frame against the scoreboard word
  bit            in_frame = 1'b0;
  int            k = 0;
  int            frames = 0;
  logic [RW-1:0] cur = '0;
  always @(negedge c) begin : rx
    int j;
    logic want;
    if (re) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("tx_idle_no_word_pending", tx, 1);
        end else begin
          cur      = exp_q.pop_front();
          in_frame = 1'b1;
          k        = 0;
        end
      end
    end else begin
      k++;
      j = k / CPB;
      if (j == 0)       want = 1'b0;
      else if (j <= RW) want = cur[j-1];
      else              want = 1'b1;
      chk($sformatf("tx w=%02h k=%0d", cur, k), tx, want);
      if (k == FRAME - 1) begin
        in_frame = 1'b0;
        frames++;
      end
    end
  end

  task automatic wait_rs(input int max);
    int t = 0;
    do begin
      @(negedge c);
      t++;
    end while (rs !== 1'b1 && t < max);
    if (rs !== 1'b1) chk("rs_timeout", rs, 1);
  endtask

  task automatic wait_frames(input int n, input int max);
    int t = 0;
    while (frames < n && t < max) begin
      @(negedge c);
      t++;
    end
    chk("frames_done", frames, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int rs0;

    // Reset held two edges with a word waiting
    re = 1'b1;
    en = 1'b1;
    push(8'hA5, 1'b1);
    repeat (2) begin
      @(negedge c);
      chk("rst_tx", tx, 1);
      chk("rst_rs", rs, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
    end
    re = 1'b0;
    @(negedge c);
    chk("first_rs_after_reset", rs, 1);

    // Single frame 8'hA5
    wait_frames(1, 100);
    @(negedge c);
    chk("busy_after_a5", busy, 0);
    chk("rs_count_a5", rs_cnt, 1);

    // 32 back-to-back words
    base = rs_t.size();
    for (int i = 0; i < 32; i++) push(RW'(i), 1'b1);
    wait_frames(33, 32 * 43 + 100);
    for (int i = 1; i < 32; i++)
      chk($sformatf("rs_gap_%0d", i), rs_t[base+i] - rs_t[base+i-1], 43);
    @(negedge c);
    chk("es_after_burst", es, 1);
    chk("err_after_burst", err, 0);
    chk("scoreboard_empty_burst", exp_q.size(), 0);

    // Drain disabled, then enable and drop en mid-frame
    en = 1'b0;
    push(8'h3C, 1'b1);
    push(8'h5A, 1'b1);
    rs0 = rs_cnt;
    repeat (200) @(negedge c);
    chk("no_rs_while_en0", rs_cnt, rs0);
    en = 1'b1;
    wait_rs(20);
    repeat (19) @(negedge c);
    en = 1'b0;
    wait_frames(34, 100);
    repeat (60) @(negedge c);
    chk("no_rs_after_en_drop", rs_cnt, rs0 + 1);
    chk("busy_after_en_drop", busy, 0);
    chk("es_word_left", es, 0);

    // Reset pulse during DATA bit 4: 8'h5A is lost, 8'hC3 follows
    push(8'hC3, 1'b1);
    en = 1'b1;
    wait_rs(20);
    repeat (23) @(negedge c);
    re = 1'b1;
    @(negedge c);
    chk("tx_after_mid_reset", tx, 1);
    chk("busy_after_mid_reset", busy, 0);
    re = 1'b0;
    @(negedge c);
    chk("rs_after_mid_reset", rs, 1);
    wait_frames(35, 100);
    chk("scoreboard_empty_reset", exp_q.size(), 0);

    // Underflow in LOAD
    @(negedge c);
    chk("err_before_uf", err, 0);
    push(8'h77, 1'b0);
    wait_rs(20);
    uf = 1'b1;
    @(negedge c);
    @(negedge c);
    uf = 1'b0;
    chk("err_after_uf", err, 1);
    chk("busy_after_uf", busy, 0);
    chk("tx_after_uf", tx, 1);
    en = 1'b0;
    repeat (50) @(negedge c);
    chk("err_sticky", err, 1);
    chk("tx_idle_after_uf", tx, 1);
    chk("no_frame_after_uf", frames, 35);
    re = 1'b1;
    @(negedge c);
    re = 1'b0;
    chk("err_cleared_by_reset", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
